// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier datapath blocks.
//   ST_IDLE / ST_SHIFT : state encoding of the result unloader FSM
//   clog2()            : constant ceil(log2(value)); returns 0 for value <= 1
package matmul_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_unloader.sv
// Parallel-in, serial-out unloader: captures one N-bit product word on an
// accepted start and streams it LSB-first as BEATS = N/W beats of W bits
// over a valid/ready interface, pulsing done after the final handshake.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   d_in       parallel word, sampled only when start is accepted
//   start      load request, accepted only while in_ready
//   in_ready   high in IDLE
//   out_data   current beat (low W bits of the shift register)
//   out_valid  high in SHIFT
//   out_ready  downstream accepts the current beat
//   out_last   current beat is the final one of the word
//   done       one-cycle pulse after the final beat handshake
//   busy       high in SHIFT, always !in_ready
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start; in_ready=1, no beat presented
// ST_SHIFT | presenting beat cnt_q; advances on each handshake
module piso_unloader
    import matmul_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d_in,
    input  logic         start,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         done,
    output logic         busy
);

    localparam int BEATS = N / W;
    // A single-beat word still needs a one-bit counter to compare against.
    localparam int CW = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    generate
        if ((W < 1) || (N < W) || ((N % W) != 0)) begin : g_bad_width
            $error("piso_unloader: N must be a positive multiple of W");
        end
    endgenerate

    logic          state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          done_q,  done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = d_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                // out_valid is implied in SHIFT, so out_ready alone is the handshake.
                // The final beat is not shifted out: the word is simply retired.
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> W;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_SHIFT);
        out_valid = (state_q == ST_SHIFT);
        out_data  = shreg_q[W-1:0];
        out_last  = (state_q == ST_SHIFT) && (cnt_q == LAST_BEAT);
        done      = done_q;
    end

endmodule

// File: tb/tb_piso_unloader.sv
module tb_piso_unloader;

    logic        clk;
    logic        reset;

    logic [31:0] a_d_in;
    logic        a_start, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_done, a_busy;
    logic [7:0]  a_out_data;

    logic [7:0]  b_d_in;
    logic        b_start, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_done, b_busy;
    logic [7:0]  b_out_data;

    int checks = 0;
    int errors = 0;

    piso_unloader #(.N(32), .W(8)) dut_a (
        .clk(clk), .reset(reset), .d_in(a_d_in), .start(a_start), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .done(a_done), .busy(a_busy)
    );

    piso_unloader #(.N(8), .W(8)) dut_b (
        .clk(clk), .reset(reset), .d_in(b_d_in), .start(b_start), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .done(b_done), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are changed and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: beat i of a 32-bit word is simply its i-th byte.
    function automatic logic [7:0] beat_of(input logic [31:0] word, input int i);
        return 8'((word >> (8 * i)) & 32'hFF);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", a_out_last); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b: valid %b ready %b expected 0 1", b_out_valid, b_in_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid c%0d: got %b expected 0", c, a_out_valid); end
            checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL idle_done c%0d: got %b expected 0", c, a_done); end
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d: got %b expected 0", c, a_busy); end
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready c%0d: got %b expected 1", c, a_in_ready); end
            step();
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_beats [4];
        exp_beats = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        a_d_in = 32'hDEADBEEF; a_start = 1'b1; a_out_ready = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid b%0d: got %b expected 1", i, a_out_valid); end
            checks++; if (a_out_data !== exp_beats[i]) begin errors++; $display("FAIL basic_data b%0d: got %h expected %h", i, a_out_data, exp_beats[i]); end
            checks++; if (a_out_last !== (i == 3)) begin errors++; $display("FAIL basic_last b%0d: got %b expected %b", i, a_out_last, (i == 3)); end
            checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_early_done b%0d: got %b expected 0", i, a_done); end
            step();
        end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", a_done); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b expected 0", a_out_valid); end
        step();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", a_done); end
    endtask

    task automatic test_backpressure();
        logic pat [7];
        logic [31:0] word;
        int idx;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        word = 32'hDEADBEEF;
        idx = 0;
        a_d_in = word; a_start = 1'b1; a_out_ready = 1'b0;
        step();
        a_start = 1'b0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, a_out_valid); end
            checks++; if (a_out_data !== beat_of(word, idx)) begin errors++; $display("FAIL bp_data c%0d: got %h expected %h", c, a_out_data, beat_of(word, idx)); end
            checks++; if (a_out_last !== (idx == 3)) begin errors++; $display("FAIL bp_last c%0d: got %b expected %b", c, a_out_last, (idx == 3)); end
            checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL bp_early_done c%0d: got %b expected 0", c, a_done); end
            a_out_ready = (c < 7) ? pat[c] : 1'b1;
            step();
            if (a_out_ready) idx++;
        end
        checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout: got %0d beats expected 4", idx); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", a_done); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b expected 1", a_in_ready); end
        a_out_ready = 1'b1;
        step();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL bp_done_pulse: got %b expected 0", a_done); end
    endtask

    task automatic test_start_during_shift();
        logic [31:0] words [2];
        words = '{32'hDEADBEEF, 32'h12345678};
        a_d_in = words[0]; a_start = 1'b1; a_out_ready = 1'b1;
        step();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) begin
                // Spurious start with the other word while streaming.
                a_start = (i == 1 || i == 2); a_d_in = 32'h12345678;
                checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL sds_valid w%0d b%0d: got %b expected 1", w, i, a_out_valid); end
                checks++; if (a_out_data !== beat_of(words[w], i)) begin errors++; $display("FAIL sds_data w%0d b%0d: got %h expected %h", w, i, a_out_data, beat_of(words[w], i)); end
                step();
            end
            checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sds_done w%0d: got %b expected 1", w, a_done); end
            // Start in the done cycle must be accepted.
            a_start = (w == 0); a_d_in = words[1];
            step();
        end
        a_start = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL sds_end_idle: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] word;
        int seen_done;
        seen_done = 0;
        a_d_in = 32'hCAFE1234; a_start = 1'b1; a_out_ready = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        checks++; if (a_out_data !== 8'hFE) begin errors++; $display("FAIL rst_pre_data: got %h expected fe", a_out_data); end
        reset = 1'b1; a_out_ready = 1'b0;
        step();
        reset = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", a_out_data); end
        for (int c = 0; c < 6; c++) begin
            if (a_done !== 1'b0) seen_done++;
            a_out_ready = 1'b1;
            step();
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", seen_done); end
        word = $urandom;
        a_d_in = word; a_start = 1'b1;
        step();
        a_start = 1'b0;
        checks++; if (a_out_data !== beat_of(word, 0) || a_out_valid !== 1'b1) begin errors++; $display("FAIL rst_restart: got %h/%b expected %h/1", a_out_data, a_out_valid, beat_of(word, 0)); end
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_single_beat();
        b_d_in = 8'hA5; b_start = 1'b1; b_out_ready = 1'b0;
        step();
        b_start = 1'b0;
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b expected 1", b_out_valid); end
        checks++; if (b_out_data !== 8'hA5) begin errors++; $display("FAIL sb_data: got %h expected a5", b_out_data); end
        checks++; if (b_out_last !== 1'b1) begin errors++; $display("FAIL sb_last: got %b expected 1", b_out_last); end
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL sb_early_done: got %b expected 0", b_done); end
        b_out_ready = 1'b1;
        step();
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b expected 1", b_done); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL sb_in_ready: got %b expected 1", b_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL sb_valid_after: got %b expected 0", b_out_valid); end
        step();
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse: got %b expected 0", b_done); end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] word, next_word;
        int idx;
        word = $urandom;
        a_d_in = word; a_start = 1'b1;
        step();
        for (int n = 0; n < 12; n++) begin
            idx = 0;
            for (int c = 0; c < 200 && idx < 4; c++) begin
                checks++; if (a_out_valid !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL rnd_valid w%0d: got %b/%b expected 1/1", n, a_out_valid, a_busy); end
                checks++; if (a_out_data !== beat_of(word, idx)) begin errors++; $display("FAIL rnd_data w%0d b%0d: got %h expected %h", n, idx, a_out_data, beat_of(word, idx)); end
                checks++; if (a_out_last !== (idx == 3)) begin errors++; $display("FAIL rnd_last w%0d b%0d: got %b expected %b", n, idx, a_out_last, (idx == 3)); end
                checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rnd_early_done w%0d: got %b expected 0", n, a_done); end
                a_out_ready = 1'($urandom_range(0, 1));
                a_start = 1'($urandom_range(0, 1));
                a_d_in = $urandom;
                step();
                if (a_out_ready) idx++;
            end
            checks++; if (idx != 4) begin errors++; $display("FAIL rnd_timeout w%0d: got %0d beats expected 4", n, idx); end
            checks++; if (a_done !== 1'b1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL rnd_done w%0d: got %b/%b expected 1/1", n, a_done, a_in_ready); end
            next_word = $urandom;
            a_d_in = next_word;
            a_start = (n < 11);
            step();
            word = next_word;
        end
        a_start = 1'b0;
        checks++; if (a_done !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_end: got %b/%b expected 0/0", a_done, a_out_valid); end
    endtask

    initial begin
        reset = 1'b1;
        a_d_in = '0; a_start = 1'b0; a_out_ready = 1'b0;
        b_d_in = '0; b_start = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_idle();
        test_basic();
        test_backpressure();
        test_start_during_shift();
        test_reset_midstream();
        test_single_beat();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_unloader.md
# piso_unloader

Parallel-in, serial-out unloader for the matrix multiplier datapath: captures one N-bit result word on a `start` strobe and streams it out as W-bit beats over a valid/ready interface. It sits downstream of the product registers and drains wide Vedic multiplier results onto a narrow output bus. It signals `done` after the final beat is accepted.

## Interface
- `N`, 64, width of the parallel input word; must be a positive multiple of `W`
- `W`, 8, width of one output beat; `BEATS = N/W` beats per word
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `d_in`  in  N  parallel word, sampled only on an accepted start
- `start`  in  1  load request; accepted only when `in_ready`=1
- `in_ready`  out  1  high in IDLE, unloader can accept a word
- `out_data`  out  W  current beat, LSB-first
- `out_valid`  out  1  `out_data` holds a valid beat
- `out_ready`  in  1  downstream accepts the beat this cycle
- `out_last`  out  1  current beat is beat BEATS-1; qualified by `out_valid`
- `done`  out  1  one-cycle pulse after the final beat handshake
- `busy`  out  1  high in SHIFT; equals `!in_ready`

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: `in_ready`=1, `out_valid`=0. On `start`=1, latch `d_in` into an N-bit shift register, clear the beat counter, and go to SHIFT.
- SHIFT: `out_valid`=1 and `out_data` = `shreg[W-1:0]`.
  - On `out_valid && out_ready` with counter < BEATS-1: shift right by W, increment the counter.
  - On `out_valid && out_ready` with counter = BEATS-1: go to IDLE and set `done` for one cycle.
- A handshake is `out_valid && out_ready` sampled at the rising edge. With `out_ready`=0, `out_data`, `out_last` and `out_valid` hold their values.
- `start` while in SHIFT is ignored. The word is dropped and internal state is unchanged.
- `out_last` = (counter == BEATS-1) && SHIFT.
- N == W: a single beat, with `out_last`=1 on that beat.
- Beat counter width: clog2(BEATS), minimum 1. It never exceeds BEATS-1.
- Reset, including mid-stream: go to IDLE, drop the current word, no `done` pulse.
- Reset values: `out_valid`=0, `out_last`=0, `done`=0, `busy`=0, `in_ready`=1, `out_data`=0, counter=0, shift register=0.

## Timing
- Start accepted at edge k: `out_valid`=1 from cycle k+1, carrying `d_in[W-1:0]`.
- With `out_ready` held at 1, the beats occupy cycles k+1 through k+BEATS.
- `done` is high in cycle k+BEATS+1. `in_ready` is also 1 in that cycle.
- Start to next start: BEATS+1 cycles minimum. There is one bubble between words. `start` in the `done` cycle is accepted.
- Each cycle with `out_ready`=0 in SHIFT adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `start` to any output.

## Structure
- Put the shared package `matmul_pkg` with:
  - the state encoding localparams `ST_IDLE`=1'b0 and `ST_SHIFT`=1'b1;
  - a constant `clog2` function, reused by other matrix multiplier blocks.
- Add an elaboration-time check that `N % W == 0` and `N >= W`; fail the build otherwise.
- No sub-module is required; the shift register and counter are inline. If reuse is wanted, factor out a `beat_counter` (load/clear/increment, terminal flag).

## Test plan
- N=32, W=8, `d_in`=0xDEADBEEF, start pulse, `out_ready`=1:
  - beats are 0xEF, 0xBE, 0xAD, 0xDE on consecutive cycles;
  - `out_last` is high only on 0xDE;
  - `done` pulses the cycle after 0xDE;
  - `in_ready` returns to 1 in that same cycle.
- Backpressure: same word, `out_ready` toggled 1,0,0,1,0,1,1:
  - `out_data` holds steady while `out_ready`=0;
  - all 4 beats arrive in order;
  - `done` occurs exactly 1 cycle after the final handshake.
- `start` with `d_in`=0x12345678 asserted during SHIFT of 0xDEADBEEF:
  - it is ignored and the output stream remains EF, BE, AD, DE;
  - `start`=1 with 0x12345678 in the `done` cycle is accepted, giving beats 78, 56, 34, 12.
- Reset asserted after the second beat handshake:
  - next cycle `out_valid`=0, `in_ready`=1, `out_data`=0;
  - no `done` pulse;
  - a new start streams from beat 0.
- N=W=8, `d_in`=0xA5: one beat 0xA5 with `out_last`=1, then `done`=1 the following cycle.
- Out of reset with no start for 20 cycles: `out_valid`, `done` and `busy` stay 0, and `in_ready` stays 1.
